// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// IFU_STATS_EN adds push/redirect statistics counters to the top level.
package ifu_pkg;

    localparam int IFU_AW      = 32;
    localparam int IFU_DW      = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [IFU_AW-1:0] PC_ALIGN_MASK =
        ~IFU_AW'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [IFU_AW-1:0] pc;
        logic [IFU_DW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous fetch buffer; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = (PW+1)'(1);

    logic [PW:0] r_wr;
    logic [PW:0] r_rd;
    T            r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (push) begin
                r_wr <= r_wr + ONE;
            end
            if (pop && !empty) begin
                r_rd <= r_rd + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr[PW-1:0]] <= push_data;
        end
    end

    assign head  = r_mem[r_rd[PW-1:0]];
    assign count = r_wr - r_rd;
    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[PW] != r_rd[PW]) &&
                   (r_wr[PW-1:0] == r_rd[PW-1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: owns the PC, issues into a 1-cycle memory, buffers words.
// Optional IFU_STATS_EN adds stat_fetch_cnt / stat_redirect_cnt outputs.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
`ifdef IFU_STATS_EN
    ,
    output logic [31:0]           stat_fetch_cnt,
    output logic [31:0]           stat_redirect_cnt
`endif
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_INC  = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] W_ALIGN = ~ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [CW:0]           OCC_MAX = (CW+1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;

    logic [ADDR_WIDTH-1:0] w_redir_pc;
    logic [CW-1:0]         w_count;
    logic [CW:0]           w_occ;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    entry_t                w_push_data;
    entry_t                w_head;

    assign w_redir_pc = redirect_pc & W_ALIGN;
    assign w_pop      = !w_empty && out_ready;
    assign w_push     = r_inflight && !redirect_valid;

    // Occupancy after this cycle's pop, plus the word in flight, plus the
    // fetch under consideration must fit in the buffer.
    assign w_occ = (CW+1)'(w_count) + (CW+1)'(r_inflight)
                 + (CW+1)'(1) - (CW+1)'(w_pop);

    assign w_issue = !redirect_valid && (w_occ <= OCC_MAX);

    assign w_push_data.pc    = r_inflight_pc;
    assign w_push_data.instr = imem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_redir_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + PC_INC;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(w_push && w_full && !w_pop)
    );

    assign imem_addr = r_pc;
    assign out_valid = !w_empty;
    assign out_pc    = w_empty ? '0 : w_head.pc;
    assign out_instr = w_empty ? '0 : w_head.instr;

`ifdef IFU_STATS_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign stat_fetch_cnt    = r_fetch_cnt;
    assign stat_redirect_cnt = r_redirect_cnt;
`endif

endmodule
